// File: rtl/spi_slave_pkg.sv
`default_nettype none
// =============================================================================
// spi_slave_pkg : shared FSM states, CRC-8 constants and word-count width
// Revision      : 1.0
// =============================================================================
package spi_slave_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int         WORD_CNT_W = 16;
    localparam logic [7:0] CRC8_POLY  = 8'h07;

    // One bit of a left-shifting CRC-8, fed in received order.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic feedback;
        feedback = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_tx_shifter.sv
`default_nettype none
// =============================================================================
// spi_slave_tx_shifter : TX word register with per-bit MISO select
// Revision             : 1.0
// =============================================================================
module spi_slave_tx_shifter #(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic              w_SPI_Clk,
    input  logic              i_Rst_L,
    input  logic              load,
    input  logic              use_next,
    input  logic [WORD_W-1:0] next_word,
    input  logic [CNT_W-1:0]  bit_cnt,
    output logic              tx_bit
);

    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] src_word;
    logic [CNT_W-1:0]  bit_idx;

    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= next_word;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign bit_idx = CNT_W'(WORD_W - 1) - bit_cnt;
        end else begin : g_lsb_first
            assign bit_idx = bit_cnt;
        end
    endgenerate

    // Before a word's first edge its bit 0 comes straight from the upcoming word.
    assign src_word = use_next ? next_word : shift_reg;
    assign tx_bit   = src_word[bit_idx];

endmodule
`default_nettype wire

// File: rtl/spi_slave_word_engine.sv
`default_nettype none
// =============================================================================
// spi_slave_word_engine : SPI slave word engine, RX words, TX holding + fill.
// Optional MOSI CRC-8 output o_RX_Crc when SPI_SLAVE_CRC8_EN is defined.
// Revision              : 1.0
// =============================================================================
module spi_slave_word_engine
    import spi_slave_pkg::*;
#(
    parameter int                WORD_W    = 8,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [WORD_W-1:0] FILL_WORD = {WORD_W{1'b1}}
) (
    input  logic                  w_SPI_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    input  logic [WORD_W-1:0]     i_TX_Word,
    input  logic                  i_TX_Valid,
    output logic                  o_TX_Ready,
    output logic [WORD_W-1:0]     o_RX_Word,
    output logic                  o_RX_Valid,
    output logic [WORD_CNT_W-1:0] o_Word_Cnt,
    output logic                  o_TX_Underrun
`ifdef SPI_SLAVE_CRC8_EN
    ,
    output logic [7:0]            o_RX_Crc
`endif
);

    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_shift;
    logic [WORD_W-1:0] rx_next;
    logic              hold_full;
    logic [WORD_W-1:0] hold_word;
    logic [WORD_W-1:0] next_tx_word;
    logic              next_tx_fill;
    logic              word_start;
    logic              word_done;
    logic              tx_transfer;
    logic              tx_bit;

    generate
        if (MSB_FIRST) begin : g_rx_msb
            assign rx_next = {rx_shift[WORD_W-2:0], i_SPI_MOSI};
        end else begin : g_rx_lsb
            assign rx_next = {i_SPI_MOSI, rx_shift[WORD_W-1:1]};
        end
    endgenerate

    assign word_start  = (state == S_IDLE) || (bit_cnt == '0);
    assign word_done   = !i_SPI_CS_n && (bit_cnt == LAST_BIT);
    assign tx_transfer = !i_SPI_CS_n && word_start;

    // A word offered on the transfer edge bypasses the empty holding register.
    always_comb begin
        next_tx_word = FILL_WORD;
        next_tx_fill = 1'b0;
        if (hold_full) begin
            next_tx_word = hold_word;
        end else if (i_TX_Valid) begin
            next_tx_word = i_TX_Word;
        end else begin
            next_tx_fill = 1'b1;
        end
    end

    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            o_RX_Valid <= 1'b0;
            o_Word_Cnt <= '0;
        end else if (i_SPI_CS_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            o_RX_Valid <= 1'b0;
            o_Word_Cnt <= '0;
        end else begin
            state      <= S_SHIFT;
            rx_shift   <= rx_next;
            o_RX_Valid <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
                bit_cnt    <= '0;
                o_RX_Valid <= 1'b1;
                if (o_Word_Cnt != {WORD_CNT_W{1'b1}}) begin
                    o_Word_Cnt <= o_Word_Cnt + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Kept outside the frame block so a mid-word abort leaves it untouched.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_Word <= '0;
        end else if (word_done) begin
            o_RX_Word <= rx_next;
        end
    end

    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_full     <= 1'b0;
            hold_word     <= '0;
            o_TX_Underrun <= 1'b0;
        end else if (tx_transfer) begin
            hold_full <= 1'b0;
            if (next_tx_fill) begin
                o_TX_Underrun <= 1'b1;
            end
        end else if (i_TX_Valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_word <= i_TX_Word;
        end
    end

    assign o_TX_Ready = !hold_full;

    spi_slave_tx_shifter #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_tx_shifter (
        .w_SPI_Clk (w_SPI_Clk),
        .i_Rst_L   (i_Rst_L),
        .load      (tx_transfer),
        .use_next  (word_start),
        .next_word (next_tx_word),
        .bit_cnt   (bit_cnt),
        .tx_bit    (tx_bit)
    );

    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : tx_bit;

`ifdef SPI_SLAVE_CRC8_EN
    // Restarts from zero on the first edge of each frame, then holds after it.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_Crc <= 8'h00;
        end else if (!i_SPI_CS_n) begin
            o_RX_Crc <= crc8_step((state == S_IDLE) ? 8'h00 : o_RX_Crc, i_SPI_MOSI);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_word_engine.sv
`default_nettype none
// =============================================================================
// tb_spi_slave_word_engine : randomized self-checking bench, 8-bit and 12-bit
// Revision                 : 1.0
// =============================================================================
module tb_spi_slave_word_engine;

    logic        clk      = 1'b0;
    logic        rst_l    = 1'b0;
    logic        cs_n     = 1'b1;
    logic        mosi     = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_word  = 8'h00;
    wire         miso;
    logic        tx_ready, rx_valid, underrun;
    logic [7:0]  rx_word;
    logic [15:0] word_cnt;

    logic        cs12_n     = 1'b1;
    logic        mosi12     = 1'b0;
    logic        tx12_valid = 1'b0;
    logic [11:0] tx12_word  = 12'h000;
    wire         miso12;
    logic        tx12_ready, rx12_valid, underrun12;
    logic [11:0] rx12_word;
    logic [15:0] word12_cnt;
`ifdef SPI_SLAVE_CRC8_EN
    logic [7:0]  rx_crc, rx12_crc;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  rx_seen[$];
    logic [11:0] rx12_seen[$];
    logic        exp_underrun = 1'b0;

    always #5 clk = ~clk;

    spi_slave_word_engine dut (
        .w_SPI_Clk     (clk),
        .i_Rst_L       (rst_l),
        .i_SPI_CS_n    (cs_n),
        .i_SPI_MOSI    (mosi),
        .o_SPI_MISO    (miso),
        .i_TX_Word     (tx_word),
        .i_TX_Valid    (tx_valid),
        .o_TX_Ready    (tx_ready),
        .o_RX_Word     (rx_word),
        .o_RX_Valid    (rx_valid),
        .o_Word_Cnt    (word_cnt),
        .o_TX_Underrun (underrun)
`ifdef SPI_SLAVE_CRC8_EN
        ,
        .o_RX_Crc      (rx_crc)
`endif
    );

    spi_slave_word_engine #(
        .WORD_W    (12),
        .MSB_FIRST (1'b0)
    ) dut12 (
        .w_SPI_Clk     (clk),
        .i_Rst_L       (rst_l),
        .i_SPI_CS_n    (cs12_n),
        .i_SPI_MOSI    (mosi12),
        .o_SPI_MISO    (miso12),
        .i_TX_Word     (tx12_word),
        .i_TX_Valid    (tx12_valid),
        .o_TX_Ready    (tx12_ready),
        .o_RX_Word     (rx12_word),
        .o_RX_Valid    (rx12_valid),
        .o_Word_Cnt    (word12_cnt),
        .o_TX_Underrun (underrun12)
`ifdef SPI_SLAVE_CRC8_EN
        ,
        .o_RX_Crc      (rx12_crc)
`endif
    );

    // Each cycle with a valid pulse logs one word; a stretched pulse logs duplicates.
    always @(negedge clk) begin
        if (rx_valid)   rx_seen.push_back(rx_word);
        if (rx12_valid) rx12_seen.push_back(rx12_word);
    end

    task automatic preload(input logic [7:0] w);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_word  = w;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Clocks nbits MSB-first bits of one word; optionally offers load_w on bit 3.
    task automatic shift_bits(input logic [7:0] mosi_w, input logic [7:0] exp_w,
                              input int nbits, input bit do_load, input logic [7:0] load_w);
        logic [7:0] got;
        logic [7:0] mask;
        got  = 8'h00;
        mask = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cs_n     = 1'b0;
            mosi     = mosi_w[7-i];
            tx_valid = do_load && (i == 3);
            tx_word  = load_w;
            #1;
            got[7-i]  = miso;
            mask[7-i] = 1'b1;
        end
        checks++;
        if ((got & mask) !== (exp_w & mask)) begin
            errors++;
            $display("FAIL miso_word got=%h exp=%h mask=%h", got, exp_w, mask);
        end
        if (nbits == 8) exp_rx.push_back(mosi_w);
    endtask

    task automatic end_frame(input int exp_cnt);
        bit bad;
        @(negedge clk);
        #1;
        checks++;
        if (word_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL word_cnt got=%0d exp=%0d", word_cnt, exp_cnt);
        end
        bad = (rx_seen.size() != exp_rx.size());
        if (!bad) foreach (exp_rx[i]) if (rx_seen[i] !== exp_rx[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rx_words got_n=%0d exp_n=%0d", rx_seen.size(), exp_rx.size());
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        #1;
        checks++;
        if (word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL word_cnt_clear got=%0d exp=0", word_cnt);
        end
        rx_seen.delete();
        exp_rx.delete();
    endtask

    task automatic test_reset();
        rst_l  = 1'b0;
        cs_n   = 1'b1;
        cs12_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        #1;
        checks += 6;
        if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        if (rx_word !== 8'h00)   begin errors++; $display("FAIL reset_rx_word got=%h exp=00", rx_word); end
        if (word_cnt !== 16'd0)  begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        if (tx12_ready !== 1'b1) begin errors++; $display("FAIL reset_tx12_ready got=%b exp=1", tx12_ready); end
    endtask

    task automatic test_single_word();
        preload(8'hA5);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL preload_ready got=%b exp=0", tx_ready); end
        shift_bits(8'h3C, 8'hA5, 8, 1'b0, 8'h00);
        end_frame(1);
        checks += 3;
        if (rx_word !== 8'h3C)          begin errors++; $display("FAIL single_rx_word got=%h exp=3c", rx_word); end
        if (underrun !== exp_underrun)  begin errors++; $display("FAIL single_underrun got=%b exp=%b", underrun, exp_underrun); end
        if (tx_ready !== 1'b1)          begin errors++; $display("FAIL single_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_two_words();
        logic [7:0] m0, m1;
        m0 = 8'($urandom);
        m1 = 8'($urandom);
        preload(8'h12);
        shift_bits(m0, 8'h12, 8, 1'b1, 8'h34);
        shift_bits(m1, 8'h34, 8, 1'b0, 8'h00);
        end_frame(2);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL two_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_abort();
        logic [7:0] w, x, m, m2, prev_rx;
        w  = 8'($urandom);
        x  = 8'($urandom);
        m  = 8'($urandom);
        m2 = 8'($urandom);
        prev_rx = rx_word;
        preload(w);
        shift_bits(m, w, 5, 1'b1, x);
        @(negedge clk);
        tx_valid = 1'b0;
        cs_n     = 1'b1;
        #1;
        checks += 3;
        if (rx_seen.size() != 0) begin errors++; $display("FAIL abort_pulse got=%0d exp=0", rx_seen.size()); end
        if (rx_word !== prev_rx) begin errors++; $display("FAIL abort_rx_word got=%h exp=%h", rx_word, prev_rx); end
        if (tx_ready !== 1'b0)   begin errors++; $display("FAIL abort_hold_kept got=%b exp=0", tx_ready); end
        shift_bits(m2, x, 8, 1'b0, 8'h00);
        end_frame(1);
    endtask

    task automatic test_back_to_back();
        int         n;
        logic [7:0] cur;
        n   = 3 + int'($urandom_range(0, 2));
        cur = 8'($urandom);
        preload(cur);
        for (int k = 0; k < n; k++) begin
            bit         ld;
            logic [7:0] lw, m;
            ld = (k < n - 1) && ($urandom_range(0, 1) == 1);
            lw = 8'($urandom);
            m  = 8'($urandom);
            shift_bits(m, cur, 8, ld, lw);
            if (k < n - 1 && !ld) exp_underrun = 1'b1;
            cur = ld ? lw : 8'hFF;
        end
        end_frame(n);
        checks++;
        if (underrun !== exp_underrun) begin errors++; $display("FAIL b2b_underrun got=%b exp=%b", underrun, exp_underrun); end
    endtask

    task automatic test_underrun();
        shift_bits(8'($urandom), 8'hFF, 8, 1'b0, 8'h00);
        end_frame(1);
        exp_underrun = 1'b1;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", underrun); end
        preload(8'h5A);
        shift_bits(8'($urandom), 8'h5A, 8, 1'b0, 8'h00);
        end_frame(1);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    endtask

    task automatic test_lsb12();
        logic [11:0] t, m2, word, exp_w, got;
        t  = 12'($urandom);
        m2 = 12'($urandom);
        @(negedge clk);
        tx12_valid = 1'b1;
        tx12_word  = t;
        @(negedge clk);
        tx12_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            word  = (w == 0) ? 12'hABC : m2;
            exp_w = (w == 0) ? t : 12'hFFF;
            got   = 12'h000;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                cs12_n = 1'b0;
                mosi12 = word[i];
                #1;
                got[i] = miso12;
            end
            checks++;
            if (got !== exp_w) begin errors++; $display("FAIL lsb12_miso got=%h exp=%h", got, exp_w); end
        end
        @(negedge clk);
        #1;
        checks += 4;
        if (rx12_seen.size() != 2 || rx12_seen[0] !== 12'hABC || rx12_seen[1] !== m2) begin
            errors++;
            $display("FAIL lsb12_rx got_n=%0d exp=abc,%h", rx12_seen.size(), m2);
        end
        if (rx12_word !== m2)        begin errors++; $display("FAIL lsb12_rx_word got=%h exp=%h", rx12_word, m2); end
        if (word12_cnt !== 16'd2)    begin errors++; $display("FAIL lsb12_cnt got=%0d exp=2", word12_cnt); end
        if (underrun12 !== 1'b1)     begin errors++; $display("FAIL lsb12_underrun got=%b exp=1", underrun12); end
        cs12_n = 1'b1;
        rx12_seen.delete();
    endtask

`ifdef SPI_SLAVE_CRC8_EN
    task automatic test_crc();
        for (int b = 0; b < 9; b++) shift_bits(8'(8'h31 + b), 8'hFF, 8, 1'b0, 8'h00);
        end_frame(9);
        exp_underrun = 1'b1;
        checks++;
        if (rx_crc !== 8'hF4) begin errors++; $display("FAIL crc8 got=%h exp=f4", rx_crc); end
    endtask
`endif

    task automatic test_reset_midword();
        logic [7:0] p, m, x;
        p = 8'($urandom);
        m = 8'($urandom);
        x = 8'($urandom);
        preload(p);
        shift_bits(m, p, 8, 1'b0, 8'h00);
        shift_bits(8'($urandom), 8'hFF, 5, 1'b1, x);
        @(negedge clk);
        tx_valid = 1'b0;
        #1;
        checks += 2;
        if (rx_word !== m)      begin errors++; $display("FAIL pre_reset_rx_word got=%h exp=%h", rx_word, m); end
        if (tx_ready !== 1'b0)  begin errors++; $display("FAIL pre_reset_ready got=%b exp=0", tx_ready); end
        rst_l = 1'b0;
        #1;
        checks += 5;
        if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        if (rx_word !== 8'h00)  begin errors++; $display("FAIL rst_rx_word got=%h exp=00", rx_word); end
        if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_word_cnt got=%0d exp=0", word_cnt); end
        if (underrun !== 1'b0)  begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        if (tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        cs_n = 1'b1;
        exp_underrun = 1'b0;
        rx_seen.delete();
        exp_rx.delete();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_abort();
        test_back_to_back();
        test_underrun();
        test_lsb12();
`ifdef SPI_SLAVE_CRC8_EN
        test_crc();
`endif
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_word_engine.md
SPI_SLAVE_WORD_ENGINE -- requirements
Module: spi_slave_word_engine

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift MSb first on both MOSI and MISO, 0 = LSb first.
REQ-003 SHALL have parameter FILL_WORD, default all-ones (WORD_W bits), meaning the word transmitted on TX underrun.
REQ-004 SHALL have ports, one per line (name direction width meaning):
 w_SPI_Clk  in  1  clock; mode-normalised SPI clock; rising edge = sample edge
 i_Rst_L  in  1  reset; asynchronous, active-low
 i_SPI_CS_n  in  1  chip select; high = frame idle, asynchronous frame clear
 i_SPI_MOSI  in  1  serial data in
 o_SPI_MISO  out  1  serial data out; high-Z while i_SPI_CS_n=1
 i_TX_Word  in  WORD_W  next word to transmit
 i_TX_Valid  in  1  i_TX_Word valid
 o_TX_Ready  out  1  holding register empty
 o_RX_Word  out  WORD_W  last complete received word
 o_RX_Valid  out  1  one-cycle pulse, o_RX_Word updated
 o_Word_Cnt  out  16  complete words received in current frame
 o_TX_Underrun  out  1  sticky: FILL_WORD was sent

Function
REQ-005 SHALL implement FSM S_IDLE, S_SHIFT; S_IDLE -> S_SHIFT on first w_SPI_Clk rising edge with i_SPI_CS_n=0; any state -> S_IDLE asynchronously on i_SPI_CS_n=1.
REQ-006 SHALL keep a bit counter 0..WORD_W-1, incremented per rising edge in S_SHIFT, wrapping to 0 after WORD_W-1; cleared in S_IDLE.
REQ-007 SHALL shift i_SPI_MOSI into the RX shift register each rising edge, order per MSB_FIRST.
REQ-008 SHALL, on the edge where counter = WORD_W-1, load o_RX_Word with the completed word (including the current bit) and assert o_RX_Valid for exactly that one cycle.
REQ-009 SHALL increment o_Word_Cnt on each completed word, saturating at 0xFFFF; clear on frame end.
REQ-010 SHALL hold a one-word TX holding register; handshake i_TX_Valid & o_TX_Ready loads it; o_TX_Ready = holding register empty.
REQ-011 SHALL, at frame start and on each word boundary, move holding register into TX shift register and mark holding empty; if empty, load FILL_WORD and set o_TX_Underrun.
REQ-012 SHALL present the first MISO bit combinationally from the holding register (or FILL_WORD) while in S_IDLE with i_SPI_CS_n=0, before the first edge.
REQ-013 SHALL update MISO on each rising edge to the next bit, so it is stable for the master's next sample edge.
REQ-014 SHALL, on a simultaneous load handshake and word-boundary transfer, pass the incoming word directly to the shift register with no underrun.
REQ-015 SHALL discard a partial word when i_SPI_CS_n rises mid-word: no o_RX_Valid, o_RX_Word unchanged, holding register content retained.
REQ-016 o_TX_Underrun SHALL clear only on reset.

Reset
REQ-017 i_Rst_L=0 SHALL force: FSM S_IDLE, counters 0, o_RX_Word 0, o_RX_Valid 0, o_Word_Cnt 0, o_TX_Underrun 0, holding register empty (o_TX_Ready=1), shift registers 0.
REQ-018 Reset SHALL take priority over i_SPI_CS_n and all handshakes.

Configuration
REQ-019 With SPI_SLAVE_CRC8_EN defined, SHALL compute CRC-8 (poly 0x07, init 0x00) over all received MOSI bits of the frame, exposed on output o_RX_Crc[7:0], cleared at frame start.
REQ-020 Without SPI_SLAVE_CRC8_EN, o_RX_Crc and its logic SHALL not exist.

Structure
REQ-021 FSM state enum, CRC-8 polynomial constant and word-count width SHALL live in shared package spi_slave_pkg.
REQ-022 Serialiser (TX shift register plus bit select) SHALL be sub-module spi_slave_tx_shifter.

Verification
REQ-023 WORD_W=8, MSB_FIRST=1, TX 0xA5 preloaded, MOSI 0x3C -> MISO 1,0,1,0,0,1,0,1; o_RX_Word=0x3C with one o_RX_Valid pulse on 8th edge.
REQ-024 Two words in one frame, TX 0x12 then 0x34 loaded mid-word 1 -> MISO 0x12,0x34; o_Word_Cnt=2; o_TX_Underrun=0.
REQ-025 No TX load, 8 edges -> MISO 0xFF, o_TX_Underrun=1 until reset.
REQ-026 CS_n rises after 5 edges -> no o_RX_Valid, o_RX_Word unchanged, next frame restarts at bit 0.
REQ-027 WORD_W=12, MSB_FIRST=0, MOSI 0xABC -> o_RX_Word=0xABC after 12 edges.
REQ-028 i_Rst_L pulsed low mid-word -> all outputs at reset values, o_TX_Ready=1; CRC (if enabled) over bytes 0x31..0x39 = 0xF4.
